apb_master_gcd: RTL and testbench
=================================

APB_MASTER_GCD -- requirements
Module: apb_master_gcd

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter POLL_MAX, default 255, maximum STATUS reads per wait phase.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports listed below (clock and reset first).
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_a  in  8  operand a
- i_b  in  8  operand b
- i_valid  in  1  command valid
- o_ready  out  1  command ready
- o_gcd  out  8  result
- o_err  out  1  timeout flag, qualified by o_valid
- o_valid  out  1  result valid
- i_ready  in  1  result accepted
- o_paddr  out  ADDR_W  APB address
- o_pwrite  out  1  APB write
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwdata  out  DATA_W  APB write data
- i_prdata  in  DATA_W  APB read data
- i_pready  in  1  APB ready

Function
REQ-005 SHALL drive the GCD register map: CTRL 0x00 (bit0 enable), STATUS 0x04 (bit1 data_in ready, bit0 data_out valid), DATA_IN 0x08 ({a,b} in bits 15:0), DATA_OUT 0x0C (gcd in bits 7:0).
REQ-006 SHALL assert o_ready only in IDLE, and capture i_a/i_b on i_valid && o_ready.
REQ-007 SHALL make each APB transfer SETUP (psel=1, penable=0, one cycle) then ACCESS (psel=1, penable=1), holding paddr/pwrite/pwdata stable until i_pready=1 is sampled.
REQ-008 SHALL wait in ACCESS indefinitely for i_pready.
REQ-009 SHALL drive psel=0 and penable=0 for at least one cycle between consecutive transfers; minimum transfer-to-transfer period is 4 cycles.
REQ-010 SHALL use main FSM states IDLE, EN_WR, POLL_IN, DIN_WR, POLL_OUT, DOUT_RD, RESP.
REQ-011 On the first command after reset, SHALL transition IDLE -> EN_WR (write CTRL=0x1) and set an internal enabled flag; later commands SHALL go IDLE -> POLL_IN.
REQ-012 POLL_IN SHALL read STATUS until bit1=1, then go to DIN_WR.
REQ-013 DIN_WR SHALL write {16'b0, a, b} to DATA_IN, then go to POLL_OUT.
REQ-014 POLL_OUT SHALL read STATUS until bit0=1, then go to DOUT_RD.
REQ-015 DOUT_RD SHALL read DATA_OUT, load o_gcd=i_prdata[7:0], o_err=0, then go to RESP.
REQ-016 SHALL keep a poll counter, cleared on entry to each poll state; when POLL_MAX reads have completed without the awaited bit, SHALL go to RESP with o_gcd=0 and o_err=1.
REQ-017 RESP SHALL hold o_valid=1 with o_gcd/o_err stable until i_ready=1, then return to IDLE; if i_valid is high at that moment it SHALL be accepted no earlier than the following cycle.
REQ-018 SHALL ignore STATUS bits not named in REQ-012/REQ-014.

Reset
REQ-019 On rst, all outputs SHALL go to 0 immediately (o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_gcd, o_valid, o_err, o_ready).
REQ-020 On rst, the FSM SHALL go to IDLE and the enabled flag and poll counter SHALL clear; o_ready=1 in the first cycle after rst deasserts.
REQ-021 Reset mid-transfer SHALL abort the transfer without completing it; the next command SHALL re-issue the CTRL write.

Structure
REQ-022 SHALL define the register offsets, the STATUS bit indices and the main FSM state enum in shared package gcd_pkg.
REQ-023 SHALL implement the single-transfer SETUP/ACCESS/gap engine as sub-module apb_master_if (start/addr/write/wdata in, done/rdata out), with the sequencer in apb_master_gcd.

Verification
REQ-024 First command after reset with a=48, b=18 against the apb_top_gcd slave -> transfer sequence CTRL write 0x1, STATUS read(s), DATA_IN write 0x00003012, STATUS read(s), DATA_OUT read; o_gcd=6, o_err=0.
REQ-025 Back-to-back commands (17,5) then (255,85) with i_ready tied 1 -> results 1 then 85, with no second CTRL write.
REQ-026 Slave model holding i_pready low for 5 cycles during ACCESS -> psel, penable, paddr and pwdata stable throughout; no extra transfer.
REQ-027 Slave model returning STATUS=0 forever -> exactly 255 STATUS reads, then o_valid=1, o_err=1, o_gcd=0.
REQ-028 rst pulsed during POLL_OUT -> psel/penable drop in the same cycle; the next command (12,8) starts with a CTRL write and returns o_gcd=4.
REQ-029 Result with i_ready held low for 10 cycles -> o_valid and o_gcd stable, o_ready=0, no APB activity.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the APB GCD master: slave register map, STATUS bit
// positions and the state encodings of the sequencer and the APB engine.
package gcd_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_DATA_IN  = 8'h08;
    localparam logic [7:0] REG_DATA_OUT = 8'h0C;

    localparam int CTRL_EN_BIT     = 0;
    localparam int ST_DIN_RDY_BIT  = 1;
    localparam int ST_DOUT_VLD_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN_WR,
        S_POLL_IN,
        S_DIN_WR,
        S_POLL_OUT,
        S_DOUT_RD,
        S_RESP
    } gcd_state_e;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SETUP,
        A_ACCESS,
        A_GAP
    } apb_state_e;

    function automatic logic is_poll(input gcd_state_e s);
        return (s == S_POLL_IN) || (s == S_POLL_OUT);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Single-transfer APB engine: SETUP, ACCESS (waits on pready), then one idle
// gap cycle during which o_done pulses and o_rdata holds the read data.
module apb_master_if
    import gcd_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic              o_psel,
    output logic              o_penable,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready
);

    apb_state_e        r_state;
    apb_state_e        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= A_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            A_IDLE:   if (i_start) w_next = A_SETUP;
            A_SETUP:  w_next = A_ACCESS;
            A_ACCESS: if (i_pready) w_next = A_GAP;
            A_GAP:    w_next = A_IDLE;
            default:  w_next = A_IDLE;
        endcase
    end

    always_comb begin
        o_psel    = (r_state == A_SETUP) || (r_state == A_ACCESS);
        o_penable = (r_state == A_ACCESS);
        o_done    = (r_state == A_GAP);
    end

    // Address/control/data are latched at start so they stay frozen through wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == A_IDLE && i_start) begin
                r_addr  <= i_addr;
                r_write <= i_write;
                r_wdata <= i_wdata;
            end
            if (r_state == A_ACCESS && i_pready) r_rdata <= i_prdata;
        end
    end

    assign o_paddr  = r_addr;
    assign o_pwrite = r_write;
    assign o_pwdata = r_wdata;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/apb_master_gcd.sv
// Command-level sequencer driving an APB GCD slave: enable once, push {a,b},
// poll STATUS with a bounded retry count, read the result back.
module apb_master_gcd
    import gcd_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int POLL_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_a,
    input  logic [7:0]        i_b,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [7:0]        o_gcd,
    output logic              o_err,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic              o_psel,
    output logic              o_penable,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready
);

    localparam int CNT_W = $clog2(POLL_MAX + 1);

    gcd_state_e        r_state;
    gcd_state_e        w_next;
    logic              r_enabled;
    logic              r_pend;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [7:0]        r_gcd;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_xfer;
    logic              w_start;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;
    logic [ADDR_W-1:0] w_addr;
    logic              w_write;
    logic [DATA_W-1:0] w_wdata;
    logic              w_accept;
    logic              w_poll_last;
    logic              w_hit;
    logic              w_timeout;
    logic              w_unused;

    apb_master_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_apb (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_addr    (w_addr),
        .i_write   (w_write),
        .i_wdata   (w_wdata),
        .o_done    (w_done),
        .o_rdata   (w_rdata),
        .o_paddr   (o_paddr),
        .o_pwrite  (o_pwrite),
        .o_psel    (o_psel),
        .o_penable (o_penable),
        .o_pwdata  (o_pwdata),
        .i_prdata  (i_prdata),
        .i_pready  (i_pready)
    );

    assign w_accept    = i_valid && o_ready;
    assign w_poll_last = (r_cnt == CNT_W'(POLL_MAX - 1));
    assign w_hit       = (r_state == S_POLL_IN) ? w_rdata[ST_DIN_RDY_BIT] : w_rdata[ST_DOUT_VLD_BIT];
    assign w_timeout   = is_poll(r_state) && w_done && !w_hit && w_poll_last;
    assign w_unused    = ^w_rdata[DATA_W-1:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = r_enabled ? S_POLL_IN : S_EN_WR;
            S_EN_WR:    if (w_done) w_next = S_POLL_IN;
            S_POLL_IN:  if (w_done && w_hit) w_next = S_DIN_WR;
                        else if (w_timeout) w_next = S_RESP;
            S_DIN_WR:   if (w_done) w_next = S_POLL_OUT;
            S_POLL_OUT: if (w_done && w_hit) w_next = S_DOUT_RD;
                        else if (w_timeout) w_next = S_RESP;
            S_DOUT_RD:  if (w_done) w_next = S_RESP;
            S_RESP:     if (i_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr  = '0;
        w_write = 1'b0;
        w_wdata = '0;
        case (r_state)
            S_EN_WR: begin
                w_addr               = ADDR_W'(REG_CTRL);
                w_write              = 1'b1;
                w_wdata[CTRL_EN_BIT] = 1'b1;
            end
            S_POLL_IN, S_POLL_OUT: w_addr = ADDR_W'(REG_STATUS);
            S_DIN_WR: begin
                w_addr  = ADDR_W'(REG_DATA_IN);
                w_write = 1'b1;
                w_wdata = DATA_W'({r_a, r_b});
            end
            S_DOUT_RD: w_addr = ADDR_W'(REG_DATA_OUT);
            default: ;
        endcase
        w_xfer  = (r_state != S_IDLE) && (r_state != S_RESP);
        w_start = w_xfer && !r_pend;
        // Gated by rst so o_ready reads 0 while reset is held.
        o_ready = (r_state == S_IDLE) && !rst;
        o_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enabled <= 1'b0;
            r_pend    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_gcd     <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_start)     r_pend <= 1'b1;
            else if (w_done) r_pend <= 1'b0;

            if (w_accept) begin
                r_a <= i_a;
                r_b <= i_b;
                if (!r_enabled) r_enabled <= 1'b1;
            end

            if (r_state != w_next && is_poll(w_next)) r_cnt <= '0;
            else if (is_poll(r_state) && w_done)      r_cnt <= r_cnt + CNT_W'(1);

            if (r_state == S_DOUT_RD && w_done) begin
                r_gcd <= w_rdata[7:0];
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_gcd <= '0;
                r_err <= 1'b1;
            end
        end
    end

    assign o_gcd = r_gcd;
    assign o_err = r_err;

endmodule

// File: tb/tb_apb_master_gcd.sv
// Directed bench for apb_master_gcd with a behavioural APB GCD slave and an
// inline protocol monitor run on every falling edge.
module tb_apb_master_gcd;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_a = '0, i_b = '0;
    logic        i_valid = 1'b0, i_ready = 1'b0;
    logic        o_ready, o_err, o_valid;
    logic [7:0]  o_gcd;
    logic [7:0]  o_paddr;
    logic        o_pwrite, o_psel, o_penable;
    logic [31:0] o_pwdata, i_prdata;
    logic        i_pready;

    always #5 clk = ~clk;

    apb_master_gcd #(.ADDR_W(8), .DATA_W(32), .POLL_MAX(255)) dut (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid),
        .o_ready(o_ready), .o_gcd(o_gcd), .o_err(o_err), .o_valid(o_valid),
        .i_ready(i_ready), .o_paddr(o_paddr), .o_pwrite(o_pwrite),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwdata(o_pwdata),
        .i_prdata(i_prdata), .i_pready(i_pready)
    );

    // ---------------- slave model ----------------
    typedef struct { logic [7:0] addr; logic wr; logic [31:0] data; } xfer_t;
    xfer_t xlog[$];

    int         s_delay = 0;
    bit         s_stuck = 1'b0;
    logic       s_en = 1'b0, s_ovalid = 1'b0;
    int         s_busy = 0;
    logic [7:0] s_dout = '0;
    int         s_wait = 0;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = y; y = x % y; x = t; end
        return x;
    endfunction

    assign i_pready = o_psel && o_penable && (s_wait >= s_delay);

    always_comb begin
        i_prdata = 32'hDEAD_BEEF;
        case (o_paddr)
            8'h00: i_prdata = {31'b0, s_en};
            8'h04: i_prdata = s_stuck ? 32'h0 :
                              (32'h0000_0F20 | {30'b0, s_en, (s_ovalid && s_busy == 0)});
            8'h0C: i_prdata = {24'hA5A5A5, s_dout};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (o_psel && o_penable && !i_pready) s_wait <= s_wait + 1;
        else                                  s_wait <= 0;
        if (o_psel && o_penable && i_pready) begin
            xlog.push_back('{o_paddr, o_pwrite, o_pwrite ? o_pwdata : i_prdata});
            if (o_pwrite) begin
                if (o_paddr == 8'h00) s_en <= o_pwdata[0];
                if (o_paddr == 8'h08) begin
                    s_dout   <= ref_gcd(o_pwdata[15:8], o_pwdata[7:0]);
                    s_ovalid <= 1'b1;
                    s_busy   <= 2;
                end
            end else begin
                if (o_paddr == 8'h04 && !s_stuck && s_ovalid && s_busy > 0) s_busy <= s_busy - 1;
                if (o_paddr == 8'h0C) s_ovalid <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;
    int waits_seen = 0;
    logic        pv_wait = 1'b0, pv_done = 1'b0, pv_psel = 1'b0;
    logic [42:0] pv_bus = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) begin
            pv_wait = 1'b0; pv_done = 1'b0; pv_psel = 1'b0;
        end else begin
            if (pv_wait) chk("access_hold", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata},
                             {2'b11, pv_bus[40:0]});
            if (pv_done) chk("gap_idle", o_psel, 1'b0);
            if (o_penable) chk("setup_first", pv_psel, 1'b1);
            pv_wait = o_psel && o_penable && !i_pready;
            pv_done = o_psel && o_penable && i_pready;
            pv_psel = o_psel;
            pv_bus  = {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata};
            if (pv_wait) waits_seen++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!o_ready && n < 100) begin tick(); n++; end
        chk("wait_ready", o_ready, 1'b1);
        i_a = a; i_b = b; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic get_resp(input int hold, output logic [7:0] g, output logic e);
        int n = 0;
        i_ready = (hold == 0);
        while (!o_valid && n < 3000) begin tick(); n++; end
        chk("wait_valid", o_valid, 1'b1);
        g = o_gcd; e = o_err;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                tick();
                chk("resp_hold", {o_valid, o_ready, o_psel, o_gcd, o_err}, {3'b100, g, e});
            end
            i_ready = 1'b1;
            tick();
            chk("resp_release", o_valid, 1'b0);
        end
    endtask

    task automatic check_seq(input int i0, input bit first, input logic [15:0] din,
                             input int n_status, input int n_total);
        int ctrl = 0, stat = 0;
        logic [31:0] dval = 32'hFFFF_FFFF;
        for (int k = i0; k < xlog.size(); k++) begin
            if (xlog[k].addr == 8'h00 && xlog[k].wr) begin
                ctrl++;
                chk("ctrl_data", xlog[k].data, 32'h1);
            end
            if (xlog[k].addr == 8'h04 && !xlog[k].wr) stat++;
            if (xlog[k].addr == 8'h08 && xlog[k].wr) dval = xlog[k].data;
        end
        chk("ctrl_writes", ctrl, first ? 1 : 0);
        if (first) chk("ctrl_is_first", {xlog[i0].addr, xlog[i0].wr}, {8'h00, 1'b1});
        chk("status_reads", stat, n_status);
        chk("total_xfers", xlog.size() - i0, n_total);
        if (din != 16'hFFFF) begin
            chk("din_word", dval, {16'h0, din});
            chk("last_is_dout", {xlog[xlog.size()-1].addr, xlog[xlog.size()-1].wr}, {8'h0C, 1'b0});
        end
    endtask

    typedef struct { logic [7:0] a, b, g; logic [15:0] din; bit first; } vec_t;
    vec_t vt[8];

    initial begin
        logic [7:0] g;
        logic       e;
        int         i0, w0;
        bit         found;

        vt[0] = '{8'd48,  8'd18,  8'd6,  16'h3012, 1'b1};
        vt[1] = '{8'd17,  8'd5,   8'd1,  16'h1105, 1'b0};
        vt[2] = '{8'd255, 8'd85,  8'd85, 16'hFF55, 1'b0};
        vt[3] = '{8'd100, 8'd75,  8'd25, 16'h644B, 1'b0};
        vt[4] = '{8'd7,   8'd7,   8'd7,  16'h0707, 1'b0};
        vt[5] = '{8'd1,   8'd255, 8'd1,  16'h01FF, 1'b0};
        vt[6] = '{8'd0,   8'd9,   8'd9,  16'h0009, 1'b0};
        vt[7] = '{8'd144, 8'd96,  8'd48, 16'h9060, 1'b0};

        #1;
        chk("reset_outputs", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_gcd, o_valid, o_err, o_ready}, 64'h0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", o_ready, 1'b1);

        // back-to-back commands, i_ready tied high
        for (int i = 0; i < 8; i++) begin
            i0 = xlog.size();
            send_cmd(vt[i].a, vt[i].b);
            get_resp(0, g, e);
            chk($sformatf("gcd_v%0d", i), g, vt[i].g);
            chk($sformatf("err_v%0d", i), e, 1'b0);
            check_seq(i0, vt[i].first, vt[i].din, 4, vt[i].first ? 7 : 6);
        end

        // slave stretches every ACCESS by 5 cycles
        s_delay = 5;
        i0 = xlog.size(); w0 = waits_seen;
        send_cmd(8'd36, 8'd60);
        get_resp(0, g, e);
        chk("gcd_slow", {e, g}, {1'b0, 8'd12});
        check_seq(i0, 1'b0, 16'h243C, 4, 6);
        chk("wait_cycles", waits_seen - w0, 30);
        s_delay = 0;

        // result held off by i_ready for 10 cycles
        i0 = xlog.size();
        send_cmd(8'd200, 8'd150);
        get_resp(10, g, e);
        chk("gcd_hold", {e, g}, {1'b0, 8'd50});
        check_seq(i0, 1'b0, 16'hC896, 4, 6);

        // reset during a POLL_OUT STATUS read
        i0 = xlog.size();
        send_cmd(8'd30, 8'd12);
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            for (int k = i0; k < xlog.size(); k++)
                if (xlog[k].addr == 8'h08 && xlog[k].wr) found = 1'b1;
            if (found && o_psel && o_penable) break;
        end
        chk("reach_poll_out", {found, o_psel, o_penable, o_paddr}, {3'b111, 8'h04});
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_gcd, o_valid, o_err, o_ready}, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst_mid", o_ready, 1'b1);
        i0 = xlog.size();
        send_cmd(8'd12, 8'd8);
        get_resp(0, g, e);
        chk("gcd_after_rst", {e, g}, {1'b0, 8'd4});
        check_seq(i0, 1'b1, 16'h0C08, 4, 7);

        // STATUS stuck at zero -> poll timeout
        s_stuck = 1'b1;
        i0 = xlog.size();
        send_cmd(8'd9, 8'd6);
        get_resp(0, g, e);
        chk("timeout_resp", {e, g}, {1'b1, 8'd0});
        check_seq(i0, 1'b0, 16'hFFFF, 255, 255);
        s_stuck = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
